logic_gates_seq: RTL and testbench



---
 rtl/logic_gates_seq.sv | 148 ++++++++++++++
 tb/tb_logic_gates_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gates_seq.sv
// Truth-table sequencer for the six 2-input gates: steps x through 00..11 per gate,
// either on a divided tick (RUN) or one step per button press (PAUSE).
module logic_gates_seq #(
    parameter int TICK_DIV = 12000000,
    parameter int CNT_W    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    output logic [1:0] x_out,
    output logic [2:0] gate_sel,
    output logic       z,
    output logic       running,
    output logic       wrap,
    output logic [5:0] leds
);

    typedef enum logic {
        S_PAUSE = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_run_s1, r_run_s2, r_run_prev;
    logic             r_step_s1, r_step_s2, r_step_prev;
    logic [2:0]       r_fill;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_combo;
    logic [2:0]       r_gate;
    logic             r_wrap;
    logic             w_run_edge, w_step_edge, w_tick;
    logic             w_step, w_cnt_clr, w_cnt_inc, w_last;
    logic             w_z;

    // r_fill masks edges until prev has caught up with a level held through reset release
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_s1    <= 1'b0;
            r_run_s2    <= 1'b0;
            r_run_prev  <= 1'b0;
            r_step_s1   <= 1'b0;
            r_step_s2   <= 1'b0;
            r_step_prev <= 1'b0;
            r_fill      <= 3'b000;
        end else begin
            r_run_s1    <= btn_run;
            r_run_s2    <= r_run_s1;
            r_run_prev  <= r_run_s2;
            r_step_s1   <= btn_step;
            r_step_s2   <= r_step_s1;
            r_step_prev <= r_step_s2;
            r_fill      <= {r_fill[1:0], 1'b1};
        end
    end

    assign w_run_edge  = r_run_s2 & ~r_run_prev & r_fill[2];
    assign w_step_edge = r_step_s2 & ~r_step_prev & r_fill[2];
    assign w_tick      = (r_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PAUSE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_PAUSE: begin
                if (w_run_edge) begin
                    w_state_nxt = S_RUN;
                    w_cnt_clr   = 1'b1;
                end else if (w_step_edge) begin
                    w_step = 1'b1;
                end
            end
            S_RUN: begin
                if (w_run_edge) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_tick) begin
                    w_step    = 1'b1;
                    w_cnt_clr = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: w_state_nxt = S_PAUSE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_last = (r_gate == 3'd5) && (r_combo == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_combo <= 2'd0;
            r_gate  <= 3'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_step & w_last;
            if (w_step) begin
                r_combo <= r_combo + 2'd1;
                if (r_combo == 2'd3) begin
                    r_gate <= (r_gate == 3'd5) ? 3'd0 : r_gate + 3'd1;
                end
            end
        end
    end

    always_comb begin
        w_z = 1'b0;
        case (r_gate)
            3'd0: w_z =   r_combo[0] & r_combo[1];
            3'd1: w_z =   r_combo[0] | r_combo[1];
            3'd2: w_z =   r_combo[0] ^ r_combo[1];
            3'd3: w_z = ~(r_combo[0] & r_combo[1]);
            3'd4: w_z = ~(r_combo[0] | r_combo[1]);
            3'd5: w_z = ~(r_combo[0] ^ r_combo[1]);
            default: w_z = 1'b0;
        endcase
    end

    assign x_out    = r_combo;
    assign gate_sel = r_gate;
    assign z        = w_z;
    assign running  = (r_state == S_RUN);
    assign wrap     = r_wrap;
    assign leds     = {r_gate, w_z, r_combo};

endmodule

// File: tb/tb_logic_gates_seq.sv
// Directed bench for logic_gates_seq with TICK_DIV=4: table of expected step results
// plus hand-written sequences for priorities, tick alignment and reset corners.
module tb_logic_gates_seq;

    logic       clk = 1'b0;
    logic       rst, btn_run, btn_step;
    logic [1:0] x_out;
    logic [2:0] gate_sel;
    logic       z, running, wrap;
    logic [5:0] leds;

    always #5 clk = ~clk;

    logic_gates_seq #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
        .x_out(x_out), .gate_sel(gate_sel), .z(z), .running(running),
        .wrap(wrap), .leds(leds)
    );

    typedef struct {
        logic [1:0] x;
        logic [2:0] g;
        logic       z;
        logic       w;
    } vec_t;

    vec_t tbl [24];
    int   n_pass = 0;
    int   n_total = 0;
    int   stray_wrap = 0;
    int   e_c = 0;
    int   e_g = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, "_x"}, 32'(x_out), 32'(v.x));
        check({tag, "_gate"}, 32'(gate_sel), 32'(v.g));
        check({tag, "_z"}, 32'(z), 32'(v.z));
        check({tag, "_wrap"}, 32'(wrap), 32'(v.w));
        check({tag, "_leds"}, 32'(leds), 32'({v.g, v.z, v.x}));
    endtask

    function automatic logic ref_z(input int g, input int c);
        logic a, b;
        a = c[0];
        b = c[1];
        case (g)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    // Waits for the next change of x_out/gate_sel, optionally toggling btn_step every cycle.
    task automatic wait_step(input bit tog, output int n, output bit got);
        logic [1:0] px;
        logic [2:0] pg;
        px  = x_out;
        pg  = gate_sel;
        n   = 0;
        got = 1'b0;
        while (n < 12 && !got) begin
            @(negedge clk);
            n++;
            if (tog) btn_step = ~btn_step;
            if (x_out != px || gate_sel != pg) got = 1'b1;
            else if (wrap) stray_wrap++;
        end
    endtask

    task automatic model_step();
        if (e_c == 3) begin
            e_c = 0;
            e_g = (e_g == 5) ? 0 : e_g + 1;
        end else begin
            e_c = e_c + 1;
        end
    endtask

    task automatic press_step();
        btn_step = 1'b1;
        repeat (3) @(negedge clk);
        btn_step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_run_until_running(input string tag);
        int n;
        btn_run = 1'b1;
        n = 0;
        while (!running && n < 10) begin
            @(negedge clk);
            n++;
        end
        btn_run = 1'b0;
        check({tag, "_running"}, 32'(running), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'd3);
    endtask

    initial begin
        int         n;
        bit         got;
        logic [1:0] px;
        logic [2:0] pg;
        logic [13:0] acc;

        tbl[0]  = '{2'b01, 3'd0, 1'b0, 1'b0};  tbl[1]  = '{2'b10, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{2'b11, 3'd0, 1'b1, 1'b0};  tbl[3]  = '{2'b00, 3'd1, 1'b0, 1'b0};
        tbl[4]  = '{2'b01, 3'd1, 1'b1, 1'b0};  tbl[5]  = '{2'b10, 3'd1, 1'b1, 1'b0};
        tbl[6]  = '{2'b11, 3'd1, 1'b1, 1'b0};  tbl[7]  = '{2'b00, 3'd2, 1'b0, 1'b0};
        tbl[8]  = '{2'b01, 3'd2, 1'b1, 1'b0};  tbl[9]  = '{2'b10, 3'd2, 1'b1, 1'b0};
        tbl[10] = '{2'b11, 3'd2, 1'b0, 1'b0};  tbl[11] = '{2'b00, 3'd3, 1'b1, 1'b0};
        tbl[12] = '{2'b01, 3'd3, 1'b1, 1'b0};  tbl[13] = '{2'b10, 3'd3, 1'b1, 1'b0};
        tbl[14] = '{2'b11, 3'd3, 1'b0, 1'b0};  tbl[15] = '{2'b00, 3'd4, 1'b1, 1'b0};
        tbl[16] = '{2'b01, 3'd4, 1'b0, 1'b0};  tbl[17] = '{2'b10, 3'd4, 1'b0, 1'b0};
        tbl[18] = '{2'b11, 3'd4, 1'b0, 1'b0};  tbl[19] = '{2'b00, 3'd5, 1'b1, 1'b0};
        tbl[20] = '{2'b01, 3'd5, 1'b0, 1'b0};  tbl[21] = '{2'b10, 3'd5, 1'b0, 1'b0};
        tbl[22] = '{2'b11, 3'd5, 1'b1, 1'b0};  tbl[23] = '{2'b00, 3'd0, 1'b0, 1'b1};

        rst = 1'b1;
        btn_run = 1'b0;
        btn_step = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("reset", '{2'b00, 3'd0, 1'b0, 1'b0});
        check("reset_running", 32'(running), 32'd0);

        // Idle: nothing moves for 100 cycles
        rst = 1'b0;
        acc = '0;
        repeat (100) begin
            @(negedge clk);
            acc = acc | {running, wrap, leds, x_out, gate_sel, z};
        end
        check("idle_outputs", 32'(acc), 32'd0);

        // Manual stepping in PAUSE
        for (int i = 0; i < 4; i++) begin
            press_step();
            check_vec($sformatf("manual%0d", i), tbl[i]);
            check($sformatf("manual%0d_running", i), 32'(running), 32'd0);
        end
        check("manual_leds_end", 32'(leds), 32'b001000);

        // Full automatic run through all six gates
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_vec("rst2", '{2'b00, 3'd0, 1'b0, 1'b0});
        press_run_until_running("run1");
        for (int i = 0; i < 24; i++) begin
            wait_step(1'b0, n, got);
            check($sformatf("auto%0d_seen", i), 32'(got), 32'd1);
            check($sformatf("auto%0d_spacing", i), 32'(n), 32'd4);
            check_vec($sformatf("auto%0d", i), tbl[i]);
        end

        // step presses in RUN add nothing
        e_c = 0;
        e_g = 0;
        for (int i = 0; i < 4; i++) begin
            wait_step(1'b1, n, got);
            model_step();
            check($sformatf("runstep%0d_spacing", i), 32'(n), 32'd4);
            check($sformatf("runstep%0d_x", i), 32'(x_out), 32'(e_c));
            check($sformatf("runstep%0d_gate", i), 32'(gate_sel), 32'(e_g));
            check($sformatf("runstep%0d_z", i), 32'(z), 32'(ref_z(e_g, e_c)));
        end
        btn_step = 1'b0;

        // run edge landing on the tick cycle: pause wins, no step
        @(negedge clk);
        btn_run = 1'b1;
        px = x_out;
        pg = gate_sel;
        repeat (3) @(negedge clk);
        check("tickrun_running", 32'(running), 32'd0);
        check("tickrun_x", 32'(x_out), 32'(px));
        check("tickrun_gate", 32'(gate_sel), 32'(pg));
        btn_run = 1'b0;
        repeat (8) @(negedge clk);
        check("paused_x", 32'(x_out), 32'(px));
        check("paused_gate", 32'(gate_sel), 32'(pg));
        check("paused_running", 32'(running), 32'd0);

        // both buttons together in PAUSE: only the toggle
        btn_run = 1'b1;
        btn_step = 1'b1;
        repeat (3) @(negedge clk);
        btn_run = 1'b0;
        btn_step = 1'b0;
        check("both_running", 32'(running), 32'd1);
        check("both_x", 32'(x_out), 32'(px));
        check("both_gate", 32'(gate_sel), 32'(pg));
        wait_step(1'b0, n, got);
        model_step();
        check("both_next_spacing", 32'(n), 32'd4);
        check("both_next_x", 32'(x_out), 32'(e_c));
        check("both_next_gate", 32'(gate_sel), 32'(e_g));

        // reset mid-RUN at gate 4 / x=10 with btn_run held through release
        n = 0;
        while (!(gate_sel == 3'd4 && x_out == 2'b10) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_g4x2", 32'({gate_sel, x_out}), 32'({3'd4, 2'b10}));
        rst = 1'b1;
        btn_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_vec("midrst", '{2'b00, 3'd0, 1'b0, 1'b0});
        check("midrst_running", 32'(running), 32'd0);
        repeat (6) @(negedge clk);
        check("held_run_running", 32'(running), 32'd0);
        check("held_run_x", 32'(x_out), 32'd0);
        btn_run = 1'b0;
        repeat (4) @(negedge clk);
        check("released_running", 32'(running), 32'd0);
        press_run_until_running("run2");

        check("stray_wrap", 32'(stray_wrap), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
